// File: rtl/pic_8259_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pic_8259_slave: single 8259-style PIC (fixed priority, ICW/OCW bus, INTA)  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pic_8259_slave #(
  parameter logic [7:0] RESET_BASE = 8'h08
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic [1:0] iBusRW,
  input  logic       iBusAdr,
  input  logic [7:0] iBusData,
  output logic [7:0] oData,
  output logic       oAck,
  input  logic [7:0] iIRQ,
  output logic       oINT,
  input  logic       iINTA,
  output logic [7:0] oVector,
  output logic       oVectorValid
);

  typedef enum logic [1:0] {
    READY     = 2'd0,
    WAIT_ICW2 = 2'd1,
    WAIT_ICW3 = 2'd2,
    WAIT_ICW4 = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       initialised_q, initialised_d;
  logic [7:0] imr_q, imr_d;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  logic [4:0] base_q, base_d;
  logic       aeoi_q, aeoi_d;
  logic       rd_isr_q, rd_isr_d;
  logic       sngl_q, sngl_d;
  logic       ic4_q, ic4_d;
  logic [7:0] irq_prev_q, irq_prev_d;
  logic [7:0] data_q, data_d;
  logic       ack_q, ack_d;
  logic       int_q, int_d;
  logic [7:0] vector_q, vector_d;
  logic       vvalid_q, vvalid_d;

  logic       found;
  logic [2:0] pick;
  logic       isr_seen;
  logic       wr, rd, icw1;

  // Lowest qualifying IR wins; any in-service bit at or above a level blocks it.
  always_comb begin
    found    = 1'b0;
    pick     = 3'd0;
    isr_seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      isr_seen = isr_seen | isr_q[n];
      if (!found && !isr_seen && irr_q[n] && !imr_q[n]) begin
        found = 1'b1;
        pick  = 3'(n);
      end
    end
  end

  assign wr   = (iBusRW == 2'b01);
  assign rd   = (iBusRW == 2'b10);
  assign icw1 = wr && !iBusAdr && iBusData[4];

  always_comb begin
    state_d       = state_q;
    initialised_d = initialised_q;
    imr_d         = imr_q;
    isr_d         = isr_q;
    base_d        = base_q;
    aeoi_d        = aeoi_q;
    rd_isr_d      = rd_isr_q;
    sngl_d        = sngl_q;
    ic4_d         = ic4_q;
    data_d        = data_q;
    vector_d      = vector_q;
    ack_d         = 1'b0;
    vvalid_d      = 1'b0;
    irq_prev_d    = iIRQ;
    irr_d         = irr_q | (iIRQ & ~irq_prev_q);
    int_d         = initialised_q && found;

    if (rd) begin
      ack_d  = 1'b1;
      data_d = iBusAdr ? imr_q : (rd_isr_q ? isr_q : irr_q);
    end

    if (wr && iBusAdr) begin
      case (state_q)
        WAIT_ICW2: begin
          base_d = iBusData[7:3];
          if (!sngl_q)    state_d = WAIT_ICW3;
          else if (ic4_q) state_d = WAIT_ICW4;
          else begin
            state_d       = READY;
            initialised_d = 1'b1;
          end
        end
        WAIT_ICW3: begin
          if (ic4_q) state_d = WAIT_ICW4;
          else begin
            state_d       = READY;
            initialised_d = 1'b1;
          end
        end
        WAIT_ICW4: begin
          aeoi_d        = iBusData[1];
          state_d       = READY;
          initialised_d = 1'b1;
        end
        default: imr_d = iBusData;
      endcase
    end else if (wr && !iBusAdr && !iBusData[4] && state_q == READY) begin
      if (!iBusData[3]) begin
        if (iBusData[7:5] == 3'b001)
          isr_d = isr_q & ~(isr_q & (~isr_q + 8'd1));
        else if (iBusData[7:5] == 3'b011)
          isr_d[iBusData[2:0]] = 1'b0;
      end else if (iBusData[1]) begin
        rd_isr_d = iBusData[0];
      end
    end

    // Arbitration above used pre-write IMR/ISR; the clear also swallows a same-cycle edge.
    if (iINTA) begin
      vvalid_d = 1'b1;
      if (initialised_q && found) begin
        vector_d    = {base_q, pick};
        irr_d[pick] = 1'b0;
        if (!aeoi_q) isr_d[pick] = 1'b1;
      end else begin
        vector_d = {base_q, 3'd7};
      end
    end

    if (icw1) begin
      imr_d         = 8'h00;
      isr_d         = 8'h00;
      irr_d         = 8'h00;
      rd_isr_d      = 1'b0;
      aeoi_d        = 1'b0;
      initialised_d = 1'b0;
      sngl_d        = iBusData[1];
      ic4_d         = iBusData[0];
      state_d       = WAIT_ICW2;
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q       <= READY;
      initialised_q <= 1'b0;
      imr_q         <= 8'hFF;
      irr_q         <= 8'h00;
      isr_q         <= 8'h00;
      base_q        <= RESET_BASE[7:3];
      aeoi_q        <= 1'b0;
      rd_isr_q      <= 1'b0;
      sngl_q        <= 1'b0;
      ic4_q         <= 1'b0;
      irq_prev_q    <= 8'h00;
      data_q        <= 8'h00;
      ack_q         <= 1'b0;
      int_q         <= 1'b0;
      vector_q      <= 8'h00;
      vvalid_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      initialised_q <= initialised_d;
      imr_q         <= imr_d;
      irr_q         <= irr_d;
      isr_q         <= isr_d;
      base_q        <= base_d;
      aeoi_q        <= aeoi_d;
      rd_isr_q      <= rd_isr_d;
      sngl_q        <= sngl_d;
      ic4_q         <= ic4_d;
      irq_prev_q    <= irq_prev_d;
      data_q        <= data_d;
      ack_q         <= ack_d;
      int_q         <= int_d;
      vector_q      <= vector_d;
      vvalid_q      <= vvalid_d;
    end
  end

  assign oData        = data_q;
  assign oAck         = ack_q;
  assign oINT         = int_q;
  assign oVector      = vector_q;
  assign oVectorValid = vvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_pic_8259_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pic_8259_slave: directed bench for pic_8259_slave with expected queue   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pic_8259_slave;

  logic       iClk = 1'b0;
  logic       iReset;
  logic [1:0] iBusRW;
  logic       iBusAdr;
  logic [7:0] iBusData;
  logic [7:0] oData;
  logic       oAck;
  logic [7:0] iIRQ;
  logic       oINT;
  logic       iINTA;
  logic [7:0] oVector;
  logic       oVectorValid;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  pic_8259_slave #(.RESET_BASE(8'h08)) dut (
    .iClk(iClk), .iReset(iReset), .iBusRW(iBusRW), .iBusAdr(iBusAdr),
    .iBusData(iBusData), .oData(oData), .oAck(oAck), .iIRQ(iIRQ),
    .oINT(oINT), .iINTA(iINTA), .oVector(oVector), .oVectorValid(oVectorValid)
  );

  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic a0, input logic [7:0] d);
    iBusAdr = a0; iBusData = d; iBusRW = 2'b01;
    tick();
    iBusRW = 2'b00;
  endtask

  task automatic rd_expect(input string tag, input logic a0, input logic [7:0] exp);
    logic [7:0] e;
    exp_q.push_back(exp);
    iBusAdr = a0; iBusRW = 2'b10;
    tick();
    iBusRW = 2'b00;
    check({tag, "_ack"}, {7'd0, oAck}, 8'd1);
    e = exp_q.pop_front();
    check(tag, oData, e);
    tick();
    check({tag, "_ack_drop"}, {7'd0, oAck}, 8'd0);
  endtask

  task automatic inta_expect(input string tag, input logic [7:0] exp);
    logic [7:0] e;
    exp_q.push_back(exp);
    iINTA = 1'b1;
    tick();
    iINTA = 1'b0;
    check({tag, "_valid"}, {7'd0, oVectorValid}, 8'd1);
    e = exp_q.pop_front();
    check(tag, oVector, e);
    tick();
    check({tag, "_valid_drop"}, {7'd0, oVectorValid}, 8'd0);
  endtask

  task automatic pulse_irq(input logic [7:0] m);
    iIRQ = m;
    tick();
    iIRQ = 8'h00;
  endtask

  task automatic wait_int(input string tag, input logic exp);
    for (int i = 0; i < 6; i++) begin
      if (oINT === exp) break;
      tick();
    end
    check(tag, {7'd0, oINT}, {7'd0, exp});
  endtask

  initial begin
    iReset = 1'b1; iBusRW = 2'b00; iBusAdr = 1'b0; iBusData = 8'h00;
    iIRQ = 8'h00; iINTA = 1'b0;
    tick(); tick();
    check("rst_int", {7'd0, oINT}, 8'd0);
    check("rst_ack", {7'd0, oAck}, 8'd0);
    check("rst_vvalid", {7'd0, oVectorValid}, 8'd0);
    check("rst_vector", oVector, 8'h00);
    check("rst_data", oData, 8'h00);
    iReset = 1'b0;
    tick();

    // Before init: spurious vector from reset base, IMR reads FFh
    inta_expect("preinit_spurious", 8'h0F);
    rd_expect("rst_imr", 1'b1, 8'hFF);

    // Reset mid-init: OCW1 accepted but not initialised, so no oINT
    wr(1'b0, 8'h13);
    iReset = 1'b1; tick(); iReset = 1'b0;
    wr(1'b1, 8'h00);
    pulse_irq(8'h01);
    tick(); tick(); tick();
    check("midinit_noint", {7'd0, oINT}, 8'd0);
    rd_expect("midinit_imr", 1'b1, 8'h00);

    // Basic init and IR0 service
    wr(1'b0, 8'h13);
    wr(1'b1, 8'h08);
    wr(1'b1, 8'h01);
    wr(1'b1, 8'hFE);
    pulse_irq(8'h01);
    wait_int("ir0_int", 1'b1);
    inta_expect("ir0_vec", 8'h08);
    wait_int("ir0_int_fall", 1'b0);
    wr(1'b0, 8'h0B);
    rd_expect("ir0_isr", 1'b0, 8'h01);
    wr(1'b0, 8'h20);
    rd_expect("ir0_eoi_isr", 1'b0, 8'h00);

    // Priority and nesting: IR3 and IR5 together
    wr(1'b1, 8'h00);
    pulse_irq(8'h28);
    wait_int("nest_int", 1'b1);
    inta_expect("nest_vec3", 8'h0B);
    tick(); tick();
    check("nest_blocked", {7'd0, oINT}, 8'd0);
    rd_expect("nest_isr", 1'b0, 8'h08);
    wr(1'b0, 8'h0A);
    rd_expect("nest_irr", 1'b0, 8'h20);
    wr(1'b0, 8'h20);
    wait_int("nest_int5", 1'b1);
    inta_expect("nest_vec5", 8'h0D);
    wr(1'b0, 8'h65);
    rd_expect("spec_eoi_irr", 1'b0, 8'h00);
    wr(1'b0, 8'h0B);
    rd_expect("spec_eoi_isr", 1'b0, 8'h00);

    // Spurious after init
    inta_expect("spurious", 8'h0F);
    rd_expect("spurious_isr", 1'b0, 8'h00);
    wr(1'b0, 8'h0A);
    rd_expect("spurious_irr", 1'b0, 8'h00);

    // AEOI mode
    wr(1'b0, 8'h13);
    wr(1'b1, 8'h08);
    wr(1'b1, 8'h03);
    pulse_irq(8'h04);
    wait_int("aeoi_int", 1'b1);
    inta_expect("aeoi_vec", 8'h0A);
    wr(1'b0, 8'h0B);
    rd_expect("aeoi_isr", 1'b0, 8'h00);
    pulse_irq(8'h02);
    tick();
    check("aeoi_ir1_int", {7'd0, oINT}, 8'd1);
    inta_expect("aeoi_vec1", 8'h09);

    // iBusRW = 11 is ignored
    iBusAdr = 1'b1; iBusData = 8'h55; iBusRW = 2'b11;
    tick();
    iBusRW = 2'b00;
    rd_expect("rw11_imr", 1'b1, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pic_8259_slave.md
PIC_8259_SLAVE -- requirements
Module: pic_8259_slave

Interface
REQ-001 Parameter: RESET_BASE, 8'h08, vector base (bits 7:3 used) loaded at reset.
REQ-002 iClk  input  1  sole clock; all state changes on its rising edge.
REQ-003 iReset  input  1  synchronous, active-high reset.
REQ-004 iBusRW  input  2  bus request from the I/O executor: bit1 = read, bit0 = write, single-cycle pulse.
REQ-005 iBusAdr  input  1  register select A0 (I/O port 20h/21h).
REQ-006 iBusData  input  8  write data.
REQ-007 oData  output  8  read data, valid while oAck = 1.
REQ-008 oAck  output  1  single-cycle read acknowledge.
REQ-009 iIRQ  input  8  interrupt request lines IR7..IR0, synchronous to iClk.
REQ-010 oINT  output  1  interrupt request to the CPU.
REQ-011 iINTA  input  1  single-cycle CPU interrupt-acknowledge pulse.
REQ-012 oVector  output  8  interrupt vector number, valid while oVectorValid = 1.
REQ-013 oVectorValid  output  1  single-cycle vector strobe.

Function
REQ-014 Read (iBusRW = 2'b10): oAck = 1 for exactly one cycle, the cycle after the request; oData is updated in that same cycle.
REQ-015 Write (iBusRW = 2'b01): no ack; the register update is visible the next cycle.
REQ-016 iBusRW = 2'b11: ignored.
REQ-017 Read with A0 = 1: returns IMR.
REQ-018 Read with A0 = 0: returns IRR or ISR, per the OCW3 select; IRR is selected after reset.
REQ-019 Init FSM states: READY, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4.
REQ-020 Write A0=0, D4=1 in any state (ICW1):
  - IMR = 00h, ISR = 00h, IRR = 00h, read select = IRR, AEOI = 0, initialised = 0;
  - latch SNGL = D1 and IC4 = D0;
  - go to WAIT_ICW2.
REQ-021 WAIT_ICW2 on any A0=1 write: base = D7:3; next state WAIT_ICW3 if SNGL=0, else WAIT_ICW4 if IC4=1, else READY.
REQ-022 WAIT_ICW3 on an A0=1 write: data discarded; next state WAIT_ICW4 if IC4=1, else READY.
REQ-023 WAIT_ICW4 on an A0=1 write: AEOI = D1; next state READY.
REQ-024 Initialised is set whenever the FSM enters READY.
REQ-025 A0=0 writes with D4=0 while not in READY are ignored.
REQ-026 READY, A0=1 write (OCW1): IMR = data.
REQ-027 READY, A0=0, D4=0, D3=0 write (OCW2):
  - D7:5 = 001 (non-specific EOI): clear the highest-priority set ISR bit;
  - D7:5 = 011 (specific EOI): clear ISR[D2:0];
  - all other codes: ignored.
REQ-028 READY, A0=0, D4=0, D3=1 write (OCW3): D1:0 = 10 selects IRR, 11 selects ISR; other values leave the select unchanged.
REQ-029 Edge detection: IRR[n] sets on a 0->1 transition of iIRQ[n], comparing against the previous-cycle sample; IMR does not block IRR setting.
REQ-030 Priority is fixed: IR0 highest, IR7 lowest.
REQ-031 oINT (registered) = initialised AND there exists n with IRR[n] & ~IMR[n], and no ISR bit at priority equal to or higher than n.
REQ-032 iINTA handling: take the highest-priority qualifying n from REQ-031. The next cycle:
  - oVector = {base, n[2:0]} and oVectorValid = 1;
  - IRR[n] is cleared;
  - ISR[n] is set unless AEOI = 1.
REQ-033 iINTA with no qualifying request, or while not initialised: spurious vector {base, 3'd7}; IRR and ISR unchanged.
REQ-034 A new iIRQ[n] edge in the same cycle as an INTA clear of IRR[n]: the clear wins and the edge is consumed.
REQ-035 An OCW1/OCW2 write and an iINTA in the same cycle: both take effect; INTA arbitration uses the pre-write IMR/ISR.
REQ-036 oINT falls within one cycle after the INTA update when no further request qualifies.

Reset
REQ-037 iReset synchronously forces the following, overriding any bus/INTA activity in the same cycle:
  - FSM = READY, initialised = 0;
  - IMR = FFh, IRR = 00h, ISR = 00h, base = RESET_BASE[7:3];
  - AEOI = 0, read select = IRR, iIRQ sample = 00h;
  - oData = 00h, oAck = 0, oINT = 0, oVector = 00h, oVectorValid = 0.
REQ-038 Reset asserted mid-init sequence: the FSM returns to READY not initialised; partial ICW data is discarded.

Verification
REQ-039 Init: ICW1=13h, ICW2=08h, ICW4=01h, OCW1=FEh; then pulse iIRQ[0] -> oINT=1; iINTA -> oVector=08h with oVectorValid one cycle; ISR=01h; oINT=0.
REQ-040 Priority and nesting:
  - IR3 and IR5 rise together, IMR=00h -> first INTA returns 0Bh;
  - with ISR[3] set, oINT stays 0 for IR5;
  - OCW2=20h -> ISR=00h, oINT=1, next INTA returns 0Dh.
REQ-041 Spurious: INTA with IRR=00h -> oVector=0Fh; IRR/ISR unchanged; before init, INTA -> {RESET_BASE[7:3],3'd7}.
REQ-042 Register reads:
  - OCW3=0Bh, read A0=0 -> ISR value with oAck one cycle after the request;
  - OCW3=0Ah -> IRR value;
  - read A0=1 -> IMR.
REQ-043 AEOI: ICW4=03h; INTA on IR2 -> vector 0Ah, ISR stays 00h; the next IR1 edge raises oINT immediately.
REQ-044 Reset after ICW1 only, then OCW1=00h and an IRQ edge -> oINT stays 0 (not initialised); IMR reads 00h.
